spi_slave: RTL

//  SPI responder: the far end of the SPI master link. Lets a board-to-board
//  or loopback bench answer our own SPI master.

---
 rtl/spi_slave_if.sv | 25 ++
 rtl/spi_slave.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI bus between a master and the spi_slave responder.
// The slave modport sees CS_N/SCLK/MOSI as inputs and drives MISO plus its enable.
interface spi_slave_if;
  logic spi_cs_n;
  logic spi_clock;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_enable;

  modport slave (
    input  spi_cs_n,
    input  spi_clock,
    input  spi_mosi,
    output spi_miso,
    output spi_miso_enable
  );

  modport master (
    output spi_cs_n,
    output spi_clock,
    output spi_mosi,
    input  spi_miso,
    input  spi_miso_enable
  );
endinterface

// File: rtl/spi_slave.sv
// SPI responder: oversamples the asynchronous SPI pins on i_clock, shifts in one
// SPI_DATA_WIDTH word per frame MSB first, and shifts out the word latched from
// i_data_in when chip select falls. Any CPOL/CPHA mode, latched per frame.
module spi_slave #(
  parameter int SPI_DATA_WIDTH = 32,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_clock_polarity,
  input  logic                      i_clock_phase,
  input  logic [SPI_DATA_WIDTH-1:0] i_data_in,
  output logic [SPI_DATA_WIDTH-1:0] o_data_out,
  output logic                      o_done,
  output logic                      o_error,
  output logic                      o_busy,
  spi_slave_if.slave                spi
);

  localparam int W  = SPI_DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Synchronizer chains (bit 0 = first stage) and edge history flops
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   cs_hist_q, cs_hist_d;
  logic                   sclk_hist_q, sclk_hist_d;

  // Frame state. The receive register only holds the W-1 bits collected before
  // the last one; the final bit is merged straight into o_data_out.
  state_e          state_q, state_d;
  logic [W-1:0]    tx_q, tx_d;
  logic [W-2:0]    rx_q, rx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cpol_q, cpol_d;
  logic            cpha_q, cpha_d;
  logic            skip_q, skip_d;
  logic [W-1:0]    data_out_q, data_out_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            busy_q, busy_d;
  logic            miso_q, miso_d;
  logic            miso_en_q, miso_en_d;

  // Decoded pin events
  logic cs_s, sclk_s, mosi_s;
  logic cs_fall_s, cs_rise_s;
  logic sclk_rise_s, sclk_fall_s;
  logic lead_s, trail_s, sample_s, drive_s;

  // Shift each asynchronous pin one stage further along its synchronizer
  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi.spi_cs_n};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.spi_clock};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.spi_mosi};
    cs_hist_d   = cs_sync_q[SYNC_STAGES-1];
    sclk_hist_d = sclk_sync_q[SYNC_STAGES-1];
  end

  // Edge detection and mapping of SCLK edges onto sample/drive per latched mode
  always_comb begin
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    cs_fall_s   = ~cs_s & cs_hist_q;
    cs_rise_s   = cs_s & ~cs_hist_q;
    sclk_rise_s = sclk_s & ~sclk_hist_q;
    sclk_fall_s = ~sclk_s & sclk_hist_q;
    lead_s      = cpol_q ? sclk_fall_s : sclk_rise_s;
    trail_s     = cpol_q ? sclk_rise_s : sclk_fall_s;
    sample_s    = cpha_q ? trail_s : lead_s;
    drive_s     = cpha_q ? lead_s : trail_s;
  end

  // Frame FSM: next state, shift registers and registered output values
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    cnt_d      = cnt_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    skip_d     = skip_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall_s) begin
          cpol_d  = i_clock_polarity;
          cpha_d  = i_clock_phase;
          tx_d    = i_data_in;
          rx_d    = '0;
          cnt_d   = '0;
          // With CPHA=1 the MSB is already on MISO, so the first drive edge must not shift
          skip_d  = i_clock_phase;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (sample_s) begin
          rx_d  = {rx_q[W-3:0], mosi_s};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            data_out_d = {rx_q, mosi_s};
            done_d     = 1'b1;
            state_d    = ST_FULL;
          end else begin
            state_d    = ST_SHIFT;
          end
        end else if (drive_s) begin
          if (skip_q) begin
            skip_d = 1'b0;
          end else begin
            tx_d   = tx_q << 1;
          end
        end else begin
          state_d = ST_SHIFT;
        end
        // Chip-select rise is applied after any same-cycle sample, so a completed
        // word reports done rather than error.
        if (cs_rise_s) begin
          error_d = (state_d == ST_SHIFT);
          state_d = ST_IDLE;
        end else begin
          error_d = 1'b0;
        end
      end
      ST_FULL: begin
        if (cs_rise_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d    = (state_d != ST_IDLE);
    miso_d    = (state_d == ST_SHIFT) ? tx_d[W-1] : 1'b0;
    miso_en_d = busy_d;
  end

  // State and output registers with synchronous reset; CS_N chain resets low so
  // a low CS_N after reset never looks like a fresh falling edge.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_hist_q   <= 1'b0;
      sclk_hist_q <= 1'b0;
      state_q     <= ST_IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      skip_q      <= 1'b0;
      data_out_q  <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      miso_q      <= 1'b0;
      miso_en_q   <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_hist_q   <= cs_hist_d;
      sclk_hist_q <= sclk_hist_d;
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      skip_q      <= skip_d;
      data_out_q  <= data_out_d;
      done_q      <= done_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      miso_q      <= miso_d;
      miso_en_q   <= miso_en_d;
    end
  end

  assign o_data_out          = data_out_q;
  assign o_done              = done_q;
  assign o_error             = error_q;
  assign o_busy              = busy_q;
  assign spi.spi_miso        = miso_q;
  assign spi.spi_miso_enable = miso_en_q;

endmodule
